// File: rtl/decode_stage_nwide.sv
// -----------------------------------------------------------------------------
// decode_stage_nwide
//
// Purpose:
//   N-wide decode stage between fetch and the issue queue. Each accepted fetch
//   bundle of WIDTH instructions is decoded lane by lane. Each lane yields its
//   register addresses and usage flags, the selected immediate, func3/func7 and
//   an illegal flag. The stage also builds the intra-bundle RAW dependency
//   matrix. The decoded bundle is then written into a DEPTH-entry
//   first-word-fall-through FIFO.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   FLUSH           synchronous flush of all buffered bundles
//   IN_VALID/READY  fetch-side handshake; IN_READY depends only on state/RST
//   IN_LANE_VALID   per-lane valid (lane 0 oldest)
//   IN_PC, IN_IR    per-lane PC and instruction, lane l at [l*XLEN +: XLEN]
//   OUT_VALID/READY issue-side handshake for the head bundle
//   OUT_*           decoded head-bundle fields, lane l at [l*w +: w]
//   OUT_DEP         bit [j*WIDTH+i] set when lane j reads rd of older lane i
//   COUNT           number of buffered bundles
// -----------------------------------------------------------------------------
module decode_stage_nwide #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [WIDTH-1:0]        IN_LANE_VALID,
    input  logic [WIDTH*XLEN-1:0]   IN_PC,
    input  logic [WIDTH*XLEN-1:0]   IN_IR,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [WIDTH-1:0]        OUT_LANE_VALID,
    output logic [WIDTH*XLEN-1:0]   OUT_PC,
    output logic [WIDTH*7-1:0]      OUT_OPCODE,
    output logic [WIDTH*3-1:0]      OUT_FUNC3,
    output logic [WIDTH*7-1:0]      OUT_FUNC7,
    output logic [WIDTH*5-1:0]      OUT_RD_ADDR,
    output logic [WIDTH*5-1:0]      OUT_RS1_ADDR,
    output logic [WIDTH*5-1:0]      OUT_RS2_ADDR,
    output logic [WIDTH-1:0]        OUT_RD_USED,
    output logic [WIDTH-1:0]        OUT_RS1_USED,
    output logic [WIDTH-1:0]        OUT_RS2_USED,
    output logic [WIDTH*XLEN-1:0]   OUT_IMM,
    output logic [WIDTH-1:0]        OUT_ILLEGAL,
    output logic [WIDTH*WIDTH-1:0]  OUT_DEP,
    output logic [$clog2(DEPTH):0]  COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_NOP    = 7'b0000000;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_used;
        logic            rs1_used;
        logic            rs2_used;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } lane_dec_t;

    typedef struct packed {
        logic [WIDTH-1:0]       lane_valid;
        logic [WIDTH*XLEN-1:0]  pc;
        logic [WIDTH*7-1:0]     opcode;
        logic [WIDTH*3-1:0]     func3;
        logic [WIDTH*7-1:0]     func7;
        logic [WIDTH*5-1:0]     rd;
        logic [WIDTH*5-1:0]     rs1;
        logic [WIDTH*5-1:0]     rs2;
        logic [WIDTH-1:0]       rd_used;
        logic [WIDTH-1:0]       rs1_used;
        logic [WIDTH-1:0]       rs2_used;
        logic [WIDTH*XLEN-1:0]  imm;
        logic [WIDTH-1:0]       illegal;
        logic [WIDTH*WIDTH-1:0] dep;
    } bundle_t;

    // Sign-extend a 32-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = XLEN'($signed(v));
    endfunction

    // Decode one lane. Invalid lanes decode to all zeros; illegal lanes keep
    // their raw fields but report no register usage and a zero immediate.
    function automatic lane_dec_t decode_lane(input logic valid, input logic [XLEN-1:0] ir);
        lane_dec_t  d;
        logic       writes_rd;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        d         = '0;
        writes_rd = 1'b0;
        imm_i = {{20{ir[31]}}, ir[31:20]};
        imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        imm_u = {ir[31:12], 12'h000};
        imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        if (valid) begin
            d.opcode = ir[6:0];
            d.func3  = ir[14:12];
            d.func7  = ir[31:25];
            d.rd     = ir[11:7];
            d.rs1    = ir[19:15];
            d.rs2    = ir[24:20];
            case (ir[6:0])
                OPC_LUI, OPC_AUIPC: begin
                    writes_rd = 1'b1;
                    d.imm     = sext32(imm_u);
                end
                OPC_JAL: begin
                    writes_rd = 1'b1;
                    d.imm     = sext32(imm_j);
                end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
                    writes_rd  = 1'b1;
                    d.rs1_used = 1'b1;
                    d.imm      = sext32(imm_i);
                end
                OPC_BRANCH: begin
                    d.rs1_used = 1'b1;
                    d.rs2_used = 1'b1;
                    d.imm      = sext32(imm_b);
                end
                OPC_STORE: begin
                    d.rs1_used = 1'b1;
                    d.rs2_used = 1'b1;
                    d.imm      = sext32(imm_s);
                end
                OPC_OP: begin
                    writes_rd  = 1'b1;
                    d.rs1_used = 1'b1;
                    d.rs2_used = 1'b1;
                end
                OPC_NOP: begin
                    writes_rd = 1'b0;
                end
                default: begin
                    d.illegal = 1'b1;
                end
            endcase
            // x0 is never a real producer, so it must not create dependencies.
            d.rd_used = writes_rd && (ir[11:7] != 5'd0);
        end
        return d;
    endfunction

    lane_dec_t       w_lane [WIDTH];
    bundle_t         w_dec;
    bundle_t         w_head;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    bundle_t         r_mem [DEPTH];

    // Combinational decode of the incoming bundle, including the RAW matrix.
    always_comb begin
        w_dec = '0;
        for (int l = 0; l < WIDTH; l++) begin
            w_lane[l] = decode_lane(IN_LANE_VALID[l], IN_IR[l*XLEN +: XLEN]);
        end
        w_dec.lane_valid = IN_LANE_VALID;
        for (int l = 0; l < WIDTH; l++) begin
            if (IN_LANE_VALID[l]) begin
                w_dec.pc[l*XLEN +: XLEN] = IN_PC[l*XLEN +: XLEN];
            end else begin
                w_dec.pc[l*XLEN +: XLEN] = '0;
            end
            w_dec.opcode[l*7 +: 7]     = w_lane[l].opcode;
            w_dec.func3[l*3 +: 3]      = w_lane[l].func3;
            w_dec.func7[l*7 +: 7]      = w_lane[l].func7;
            w_dec.rd[l*5 +: 5]         = w_lane[l].rd;
            w_dec.rs1[l*5 +: 5]        = w_lane[l].rs1;
            w_dec.rs2[l*5 +: 5]        = w_lane[l].rs2;
            w_dec.rd_used[l]           = w_lane[l].rd_used;
            w_dec.rs1_used[l]          = w_lane[l].rs1_used;
            w_dec.rs2_used[l]          = w_lane[l].rs2_used;
            w_dec.imm[l*XLEN +: XLEN]  = w_lane[l].imm;
            w_dec.illegal[l]           = w_lane[l].illegal;
        end
        // Only younger lanes (j) can depend on older ones (i); diagonal and
        // upper triangle stay zero.
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((i < j) && IN_LANE_VALID[i] && IN_LANE_VALID[j] && w_lane[i].rd_used &&
                    ((w_lane[j].rs1_used && (w_lane[j].rs1 == w_lane[i].rd)) ||
                     (w_lane[j].rs2_used && (w_lane[j].rs2 == w_lane[i].rd)))) begin
                    w_dec.dep[j*WIDTH+i] = 1'b1;
                end else begin
                    w_dec.dep[j*WIDTH+i] = 1'b0;
                end
            end
        end
    end

    // Ready depends only on occupancy so that a pop never opens a same-cycle
    // push into a full FIFO. Flush wins over both push and pop.
    assign w_full    = (r_count == CW'(DEPTH));
    assign IN_READY  = !RST && !w_full;
    assign OUT_VALID = (r_count != '0);
    assign w_push    = IN_VALID && IN_READY && (|IN_LANE_VALID) && !FLUSH;
    assign w_pop     = OUT_VALID && OUT_READY && !FLUSH;

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Bundle storage; reset clears every entry so all outputs read zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_mem[d] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign OUT_LANE_VALID = OUT_VALID ? w_head.lane_valid : '0;
    assign OUT_PC         = w_head.pc;
    assign OUT_OPCODE     = w_head.opcode;
    assign OUT_FUNC3      = w_head.func3;
    assign OUT_FUNC7      = w_head.func7;
    assign OUT_RD_ADDR    = w_head.rd;
    assign OUT_RS1_ADDR   = w_head.rs1;
    assign OUT_RS2_ADDR   = w_head.rs2;
    assign OUT_RD_USED    = w_head.rd_used;
    assign OUT_RS1_USED   = w_head.rs1_used;
    assign OUT_RS2_USED   = w_head.rs2_used;
    assign OUT_IMM        = w_head.imm;
    assign OUT_ILLEGAL    = w_head.illegal;
    assign OUT_DEP        = w_head.dep;
    assign COUNT          = r_count;

endmodule

// File: tb/tb_decode_stage_nwide.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_nwide
//
// Self-checking bench for decode_stage_nwide (WIDTH=2, DEPTH=2, XLEN=32).
// Directed scenarios cover the worked decode examples, backpressure, flush and
// reset. A randomized phase compares every cycle against a queue-based
// reference model that decodes straight from the instruction-set rules.
// -----------------------------------------------------------------------------
module tb_decode_stage_nwide;

    localparam int W = 2;
    localparam int D = 2;
    localparam int X = 32;
    localparam int OBSW = W + W*X + W*7 + W*3 + W*7 + 3*W*5 + 3*W + W*X + W + W*W;

    logic            CLK = 1'b0;
    logic            RST;
    logic            FLUSH;
    logic            IN_VALID;
    logic            IN_READY;
    logic [W-1:0]    IN_LANE_VALID;
    logic [W*X-1:0]  IN_PC;
    logic [W*X-1:0]  IN_IR;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [W-1:0]    OUT_LANE_VALID;
    logic [W*X-1:0]  OUT_PC;
    logic [W*7-1:0]  OUT_OPCODE;
    logic [W*3-1:0]  OUT_FUNC3;
    logic [W*7-1:0]  OUT_FUNC7;
    logic [W*5-1:0]  OUT_RD_ADDR;
    logic [W*5-1:0]  OUT_RS1_ADDR;
    logic [W*5-1:0]  OUT_RS2_ADDR;
    logic [W-1:0]    OUT_RD_USED;
    logic [W-1:0]    OUT_RS1_USED;
    logic [W-1:0]    OUT_RS2_USED;
    logic [W*X-1:0]  OUT_IMM;
    logic [W-1:0]    OUT_ILLEGAL;
    logic [W*W-1:0]  OUT_DEP;
    logic [$clog2(D):0] COUNT;

    decode_stage_nwide #(.WIDTH(W), .DEPTH(D), .XLEN(X)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LANE_VALID(IN_LANE_VALID),
        .IN_PC(IN_PC), .IN_IR(IN_IR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LANE_VALID(OUT_LANE_VALID),
        .OUT_PC(OUT_PC), .OUT_OPCODE(OUT_OPCODE), .OUT_FUNC3(OUT_FUNC3), .OUT_FUNC7(OUT_FUNC7),
        .OUT_RD_ADDR(OUT_RD_ADDR), .OUT_RS1_ADDR(OUT_RS1_ADDR), .OUT_RS2_ADDR(OUT_RS2_ADDR),
        .OUT_RD_USED(OUT_RD_USED), .OUT_RS1_USED(OUT_RS1_USED), .OUT_RS2_USED(OUT_RS2_USED),
        .OUT_IMM(OUT_IMM), .OUT_ILLEGAL(OUT_ILLEGAL), .OUT_DEP(OUT_DEP), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    logic [OBSW-1:0] obs;
    assign obs = {OUT_LANE_VALID, OUT_PC, OUT_OPCODE, OUT_FUNC3, OUT_FUNC7,
                  OUT_RD_ADDR, OUT_RS1_ADDR, OUT_RS2_ADDR,
                  OUT_RD_USED, OUT_RS1_USED, OUT_RS2_USED, OUT_IMM, OUT_ILLEGAL, OUT_DEP};

    int n_checks = 0;
    int n_fail   = 0;
    logic [OBSW-1:0] exp_q [$];

    // Reference decode of a whole bundle, written from the ISA rules.
    function automatic logic [OBSW-1:0] model_bundle(input logic [W-1:0] lv,
                                                     input logic [W*X-1:0] pc,
                                                     input logic [W*X-1:0] ir);
        logic [W*X-1:0] m_pc, m_imm;
        logic [W*7-1:0] m_op, m_f7;
        logic [W*3-1:0] m_f3;
        logic [W*5-1:0] m_rd, m_rs1, m_rs2;
        logic [W-1:0]   m_ru, m_r1u, m_r2u, m_ill;
        logic [W*W-1:0] m_dep;
        logic [31:0]        x;
        logic signed [31:0] sx;
        logic [6:0]         op;
        m_pc = '0; m_imm = '0; m_op = '0; m_f7 = '0; m_f3 = '0;
        m_rd = '0; m_rs1 = '0; m_rs2 = '0;
        m_ru = '0; m_r1u = '0; m_r2u = '0; m_ill = '0; m_dep = '0;
        for (int l = 0; l < W; l++) begin
            if (lv[l]) begin
                x  = ir[l*X +: X];
                sx = x;
                op = x[6:0];
                m_pc[l*X +: X]  = pc[l*X +: X];
                m_op[l*7 +: 7]  = op;
                m_f3[l*3 +: 3]  = x[14:12];
                m_f7[l*7 +: 7]  = x[31:25];
                m_rd[l*5 +: 5]  = x[11:7];
                m_rs1[l*5 +: 5] = x[19:15];
                m_rs2[l*5 +: 5] = x[24:20];
                if (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011,
                               7'b0000000}) begin
                    m_ru[l]  = !(op inside {7'b1100011, 7'b0100011, 7'b0000000}) && (x[11:7] != 5'd0);
                    m_r1u[l] = !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000});
                    m_r2u[l] = op inside {7'b1100011, 7'b0100011, 7'b0110011};
                    if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011})
                        m_imm[l*X +: X] = 32'(sx >>> 20);
                    else if (op == 7'b0100011)
                        m_imm[l*X +: X] = (32'(sx >>> 25) << 5) | 32'(x[11:7]);
                    else if (op == 7'b1100011)
                        m_imm[l*X +: X] = (32'(sx >>> 31) << 12) | (32'(x[7]) << 11) |
                                          (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
                    else if (op inside {7'b0110111, 7'b0010111})
                        m_imm[l*X +: X] = x & 32'hFFFF_F000;
                    else if (op == 7'b1101111)
                        m_imm[l*X +: X] = (32'(sx >>> 31) << 20) | (32'(x[19:12]) << 12) |
                                          (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
                end else begin
                    m_ill[l] = 1'b1;
                end
            end
        end
        for (int j = 0; j < W; j++)
            for (int i = 0; i < j; i++)
                if (lv[i] && lv[j] && m_ru[i] &&
                    ((m_r1u[j] && m_rs1[j*5 +: 5] == m_rd[i*5 +: 5]) ||
                     (m_r2u[j] && m_rs2[j*5 +: 5] == m_rd[i*5 +: 5])))
                    m_dep[j*W+i] = 1'b1;
        return {lv, m_pc, m_op, m_f3, m_f7, m_rd, m_rs1, m_rs2, m_ru, m_r1u, m_r2u, m_imm, m_ill, m_dep};
    endfunction

    // Random instruction with small register numbers so that RAW hits are common.
    function automatic logic [31:0] rand_ir();
        logic [31:0] x;
        x = $urandom;
        x[11:7]  = 5'($urandom_range(0, 3));
        x[19:15] = 5'($urandom_range(0, 3));
        x[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 12))
            0:  x[6:0] = 7'b0110111;
            1:  x[6:0] = 7'b0010111;
            2:  x[6:0] = 7'b1101111;
            3:  x[6:0] = 7'b1100111;
            4:  x[6:0] = 7'b1100011;
            5:  x[6:0] = 7'b0000011;
            6:  x[6:0] = 7'b0100011;
            7:  x[6:0] = 7'b0010011;
            8:  x[6:0] = 7'b0110011;
            9:  x[6:0] = 7'b1110011;
            10: x[6:0] = 7'b0000000;
            default: x[6:0] = x[6:0];
        endcase
        return x;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic [W-1:0] lv, input logic [31:0] ir0, input logic [31:0] ir1,
                         input logic [31:0] pc0, input logic [31:0] pc1);
        IN_LANE_VALID = lv;
        IN_IR         = {ir1, ir0};
        IN_PC         = {pc1, pc0};
    endtask

    task automatic send(input logic [W-1:0] lv, input logic [31:0] ir0, input logic [31:0] ir1);
        drive(lv, ir0, ir1, 32'h0000_1000, 32'h0000_1004);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic pop_one();
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        drive('0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick(); tick();
        n_checks++;
        if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", IN_READY); end
        n_checks++;
        if (obs !== '0 || OUT_VALID !== 1'b0 || COUNT !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs valid=%b count=%0d obs=%h exp all 0", OUT_VALID, COUNT, obs);
        end
        RST = 1'b0;
        tick();
        n_checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_ready got ready=%b valid=%b exp 1/0", IN_READY, OUT_VALID);
        end
    endtask

    task automatic test_decode();
        logic [OBSW-1:0] e;
        // addi x5,x0,1 ; add x6,x5,x5
        send(2'b11, 32'h0010_0293, 32'h0052_8333);
        e = model_bundle(2'b11, {32'h0000_1004, 32'h0000_1000}, {32'h0052_8333, 32'h0010_0293});
        n_checks++;
        if ({OUT_VALID, OUT_RD_ADDR[4:0], OUT_RD_USED[0], OUT_RS1_USED[0], OUT_RS2_USED[0], OUT_IMM[31:0]}
            !== {1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 32'd1}) begin
            n_fail++; $display("FAIL addi_lane0 got v=%b rd=%0d u=%b%b%b imm=%h", OUT_VALID, OUT_RD_ADDR[4:0],
                               OUT_RD_USED[0], OUT_RS1_USED[0], OUT_RS2_USED[0], OUT_IMM[31:0]);
        end
        n_checks++;
        if ({OUT_RS1_ADDR[9:5], OUT_RS2_ADDR[9:5], OUT_RS2_USED[1]} !== {5'd5, 5'd5, 1'b1}) begin
            n_fail++; $display("FAIL add_lane1 got rs1=%0d rs2=%0d rs2u=%b exp 5 5 1",
                               OUT_RS1_ADDR[9:5], OUT_RS2_ADDR[9:5], OUT_RS2_USED[1]);
        end
        n_checks++;
        if (OUT_DEP !== 4'b0100) begin n_fail++; $display("FAIL dep_raw got=%b exp=0100", OUT_DEP); end
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL model_addi_add got=%h exp=%h", obs, e); end
        pop_one();

        // sw x6,4(x2)
        send(2'b01, 32'h0061_2223, 32'h0000_0000);
        n_checks++;
        if ({OUT_RD_USED[0], OUT_RS1_ADDR[4:0], OUT_RS2_ADDR[4:0], OUT_RS2_USED[0], OUT_IMM[31:0], OUT_FUNC3[2:0]}
            !== {1'b0, 5'd2, 5'd6, 1'b1, 32'd4, 3'b010}) begin
            n_fail++; $display("FAIL sw_decode got rdu=%b rs1=%0d rs2=%0d rs2u=%b imm=%h f3=%b", OUT_RD_USED[0],
                               OUT_RS1_ADDR[4:0], OUT_RS2_ADDR[4:0], OUT_RS2_USED[0], OUT_IMM[31:0], OUT_FUNC3[2:0]);
        end
        pop_one();

        // addi x0,x0,0 ; add x7,x0,x0 -> no dependency through x0
        send(2'b11, 32'h0000_0013, 32'h0000_03B3);
        n_checks++;
        if ({OUT_RD_USED[0], OUT_DEP} !== 5'b0_0000) begin
            n_fail++; $display("FAIL x0_no_dep got rdu=%b dep=%b exp 0 0000", OUT_RD_USED[0], OUT_DEP);
        end
        pop_one();

        // illegal opcode
        send(2'b01, 32'hFFFF_FFFF, 32'h0000_0000);
        n_checks++;
        if ({OUT_ILLEGAL[0], OUT_RD_USED[0], OUT_RS1_USED[0], OUT_RS2_USED[0], OUT_IMM[31:0]}
            !== {1'b1, 3'b000, 32'd0}) begin
            n_fail++; $display("FAIL illegal got ill=%b used=%b%b%b imm=%h", OUT_ILLEGAL[0],
                               OUT_RD_USED[0], OUT_RS1_USED[0], OUT_RS2_USED[0], OUT_IMM[31:0]);
        end
        pop_one();

        // bundle with no valid lanes completes handshake but is not stored
        send(2'b00, 32'h0010_0293, 32'h0010_0293);
        n_checks++;
        if (COUNT !== 2'd0 || OUT_VALID !== 1'b0) begin
            n_fail++; $display("FAIL empty_bundle got count=%0d valid=%b exp 0 0", COUNT, OUT_VALID);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a0, a1, b0, b1, c0, c1;
        logic [OBSW-1:0] ea, eb, ec;
        a0 = rand_ir(); a1 = rand_ir(); b0 = rand_ir(); b1 = rand_ir(); c0 = rand_ir(); c1 = rand_ir();
        ea = model_bundle(2'b11, {32'h0000_1004, 32'h0000_1000}, {a1, a0});
        eb = model_bundle(2'b11, {32'h0000_1004, 32'h0000_1000}, {b1, b0});
        ec = model_bundle(2'b11, {32'h0000_1004, 32'h0000_1000}, {c1, c0});
        OUT_READY = 1'b0;
        send(2'b11, a0, a1);
        n_checks++;
        if (COUNT !== 2'd1) begin n_fail++; $display("FAIL bp_count1 got=%0d exp=1", COUNT); end
        send(2'b11, b0, b1);
        n_checks++;
        if (COUNT !== 2'd2 || IN_READY !== 1'b0) begin
            n_fail++; $display("FAIL bp_full got count=%0d ready=%b exp 2 0", COUNT, IN_READY);
        end
        drive(2'b11, c0, c1, 32'h0000_1000, 32'h0000_1004);
        IN_VALID = 1'b1;
        tick();
        n_checks++;
        if (COUNT !== 2'd2 || obs !== ea) begin
            n_fail++; $display("FAIL bp_refused got count=%0d head=%h exp 2 %h", COUNT, obs, ea);
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        n_checks++;
        if (COUNT !== 2'd1 || IN_READY !== 1'b1 || obs !== eb) begin
            n_fail++; $display("FAIL bp_pop_full got count=%0d ready=%b head=%h exp 1 1 %h", COUNT, IN_READY, obs, eb);
        end
        tick();
        IN_VALID = 1'b0;
        n_checks++;
        if (COUNT !== 2'd2) begin n_fail++; $display("FAIL bp_third_accept got=%0d exp=2", COUNT); end
        pop_one();
        n_checks++;
        if (obs !== ec || COUNT !== 2'd1) begin
            n_fail++; $display("FAIL bp_wrap_order got count=%0d head=%h exp 1 %h", COUNT, obs, ec);
        end
    endtask

    task automatic test_flush();
        logic [31:0] g0;
        logic [OBSW-1:0] eg;
        send(2'b11, rand_ir(), rand_ir());
        drive(2'b11, rand_ir(), rand_ir(), 32'h0000_2000, 32'h0000_2004);
        FLUSH = 1'b1; IN_VALID = 1'b1;
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        n_checks++;
        if (COUNT !== 2'd0 || OUT_VALID !== 1'b0 || OUT_LANE_VALID !== 2'b00) begin
            n_fail++; $display("FAIL flush_full got count=%0d valid=%b lv=%b exp 0 0 00", COUNT, OUT_VALID, OUT_LANE_VALID);
        end
        send(2'b01, rand_ir(), rand_ir());
        drive(2'b11, rand_ir(), rand_ir(), 32'h0000_3000, 32'h0000_3004);
        FLUSH = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        n_checks++;
        if (COUNT !== 2'd0 || IN_READY !== 1'b1) begin
            n_fail++; $display("FAIL flush_push_pop got count=%0d ready=%b exp 0 1", COUNT, IN_READY);
        end
        g0 = rand_ir();
        eg = model_bundle(2'b01, {32'h0000_1004, 32'h0000_1000}, {32'h0000_0000, g0});
        send(2'b01, g0, 32'h0000_0000);
        n_checks++;
        if (COUNT !== 2'd1 || obs !== eg) begin
            n_fail++; $display("FAIL flush_after_push got count=%0d head=%h exp 1 %h", COUNT, obs, eg);
        end
        pop_one();
    endtask

    task automatic test_reset_midstream();
        logic [31:0] k0, k1;
        logic [OBSW-1:0] ek;
        send(2'b11, rand_ir(), rand_ir());
        drive(2'b11, rand_ir(), rand_ir(), 32'h0000_4000, 32'h0000_4004);
        RST = 1'b1; IN_VALID = 1'b1;
        #1;
        n_checks++;
        if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=0", IN_READY); end
        @(negedge CLK);
        n_checks++;
        if (obs !== '0 || OUT_VALID !== 1'b0 || COUNT !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs valid=%b count=%0d obs=%h exp all 0", OUT_VALID, COUNT, obs);
        end
        RST = 1'b0;
        k0 = rand_ir(); k1 = rand_ir();
        ek = model_bundle(2'b11, {32'h0000_1004, 32'h0000_1000}, {k1, k0});
        send(2'b11, k0, k1);
        n_checks++;
        if (OUT_VALID !== 1'b1 || obs !== ek) begin
            n_fail++; $display("FAIL rst_mid_first_push got valid=%b head=%h exp 1 %h", OUT_VALID, obs, ek);
        end
        pop_one();
    endtask

    task automatic test_random();
        logic            push, pop, fl;
        logic [W-1:0]    lv;
        logic [31:0]     i0, i1, p0, p1;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++;
            if (COUNT !== 2'(exp_q.size()) || IN_READY !== (exp_q.size() < D) || OUT_VALID !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL rand_state cyc=%0d got count=%0d ready=%b valid=%b exp count=%0d",
                                   cyc, COUNT, IN_READY, OUT_VALID, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                if (obs !== exp_q[0]) begin
                    n_fail++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, obs, exp_q[0]);
                end
            end else begin
                n_checks++;
                if (OUT_LANE_VALID !== 2'b00) begin
                    n_fail++; $display("FAIL rand_empty_lv cyc=%0d got=%b exp=00", cyc, OUT_LANE_VALID);
                end
            end
            lv = 2'($urandom_range(0, 3));
            i0 = rand_ir(); i1 = rand_ir(); p0 = $urandom; p1 = $urandom;
            drive(lv, i0, i1, p0, p1);
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 2) == 0);
            fl        = ($urandom_range(0, 31) == 0);
            FLUSH     = fl;
            push = IN_VALID && (exp_q.size() < D) && (lv != 2'b00) && !fl;
            pop  = (exp_q.size() != 0) && OUT_READY && !fl;
            tick();
            if (fl) begin
                exp_q.delete();
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(model_bundle(lv, {p1, p0}, {i1, i0}));
            end
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
